// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, reset vector and address-field width helpers for the instruction cache
package icache_pkg;

    typedef enum logic {IDLE = 1'b0, REFILL = 1'b1} state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_refill.sv
// icache_refill: miss FSM that walks one line from memory a beat at a time and strobes writes into the arrays
module icache_refill import icache_pkg::*; #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic [29-off_w(WORDS_PER_LINE):0]            line_addr,
    input  logic                                         hit,
    input  logic                                         Flush,
    input  logic                                         Mem_Ack,
    output logic                                         busy,
    output logic                                         Mem_Req,
    output logic [31:0]                                  Mem_Addr,
    output logic                                         wr_en,
    output logic [idx_w(LINES)-1:0]                      wr_index,
    output logic [off_w(WORDS_PER_LINE)-1:0]             wr_word,
    output logic [tag_w(LINES, WORDS_PER_LINE)-1:0]      wr_tag,
    output logic                                         line_done,
    output logic                                         commit
);

    localparam int OW = off_w(WORDS_PER_LINE);
    localparam int IW = idx_w(LINES);
    localparam int LW = 30 - OW;

    state_t         state, state_n;
    logic [LW-1:0]  base;
    logic [OW-1:0]  beat;
    logic           dirty;

    assign busy     = state == REFILL;
    assign Mem_Req  = busy;
    assign Mem_Addr = {base, beat, 2'b00};
    assign wr_index = base[IW-1:0];
    assign wr_tag   = base[LW-1:IW];
    assign wr_word  = beat;
    assign commit   = line_done && !dirty && !Flush;

    // next state: leave IDLE on a miss, leave REFILL on the ack of the last beat
    always_comb begin
        wr_en     = busy && Mem_Ack;
        line_done = wr_en && &beat;
        state_n   = !busy ? (hit ? IDLE : REFILL) : (line_done ? IDLE : REFILL);
    end

    // state, latched line base, beat counter and dirty-refill flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            base  <= '0;
            beat  <= '0;
            dirty <= 1'b0;
        end else begin
            state <= state_n;
            if (!busy && !hit) begin
                base  <= line_addr;
                beat  <= '0;
                dirty <= 1'b0;
            end else if (busy) begin
                beat  <= beat + OW'(wr_en);
                dirty <= dirty || Flush;
            end
        end
    end

endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with same-cycle hits and line refill on miss
module icache_direct import icache_pkg::*; #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_address_fIF,
    output logic [31:0] Instr1_2IF,
    output logic [1:0]  Valid,
    input  logic        Flush,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Data
);

    localparam int OW = off_w(WORDS_PER_LINE);
    localparam int IW = idx_w(LINES);
    localparam int TW = tag_w(LINES, WORDS_PER_LINE);

    logic [OW-1:0] off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          hit, busy, wr_en, line_done, commit, unused_bits;
    logic [IW-1:0] wr_index;
    logic [OW-1:0] wr_word;
    logic [TW-1:0] wr_tag;
    logic [LINES-1:0] vld;
    logic [TW-1:0]    tag_arr  [LINES];
    logic [31:0]      data_arr [LINES][WORDS_PER_LINE];

    assign off         = Instr_address_fIF[OW+1:2];
    assign idx         = Instr_address_fIF[OW+IW+1:OW+2];
    assign tag         = Instr_address_fIF[31:OW+IW+2];
    assign unused_bits = ^Instr_address_fIF[1:0];
    assign hit         = vld[idx] && tag_arr[idx] == tag;
    assign Valid       = {1'b0, hit && !busy};
    assign Instr1_2IF  = Valid[0] ? data_arr[idx][off] : '0;

    icache_refill #(.LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE)) u_refill (
        .CLK       (CLK),
        .RESET     (RESET),
        .line_addr (Instr_address_fIF[31:OW+2]),
        .hit       (hit),
        .Flush     (Flush),
        .Mem_Ack   (Mem_Ack),
        .busy      (busy),
        .Mem_Req   (Mem_Req),
        .Mem_Addr  (Mem_Addr),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_word   (wr_word),
        .wr_tag    (wr_tag),
        .line_done (line_done),
        .commit    (commit)
    );

    // valid bits: flush wins, a clean refill sets its line
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) vld <= '0;
        else if (Flush) vld <= '0;
        else if (commit) vld[wr_index] <= 1'b1;
    end

    // data words land per beat, the tag lands with the last beat
    always_ff @(posedge CLK) begin
        if (wr_en) data_arr[wr_index][wr_word] <= Mem_Data;
        if (line_done) tag_arr[wr_index] <= wr_tag;
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: random and directed fetch traffic checked against a line-level cache model
module tb_icache_direct;
    import icache_pkg::*;

    localparam int L = 64;
    localparam int W = 4;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        CLK = 1'b0;
    logic        RESET, Flush, Mem_Req, Mem_Ack, ack_en;
    logic [31:0] addr, Instr, Mem_Addr, Mem_Data;
    logic [1:0]  Valid;

    always #5 CLK = ~CLK;

    assign Mem_Ack  = Mem_Req & ack_en;
    assign Mem_Data = Mem_Ack ? (Mem_Addr ^ K) : 32'h0;

    icache_direct #(.LINES(L), .WORDS_PER_LINE(W)) icache (
        .CLK               (CLK),
        .RESET             (RESET),
        .Instr_address_fIF (addr),
        .Instr1_2IF        (Instr),
        .Valid             (Valid),
        .Flush             (Flush),
        .Mem_Req           (Mem_Req),
        .Mem_Addr          (Mem_Addr),
        .Mem_Ack           (Mem_Ack),
        .Mem_Data          (Mem_Data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    bit          m_vld  [L];
    logic [31:0] m_tag  [L];
    logic [31:0] m_data [L][W];
    bit          m_busy, m_dirty;
    logic [31:0] m_base;
    int          m_beat;

    task automatic model_reset();
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_busy  = 1'b0;
        m_dirty = 1'b0;
        m_beat  = 0;
    endtask

    task automatic clear_all();
        foreach (m_vld[i]) m_vld[i] = 1'b0;
    endtask

    task automatic step(input logic [31:0] a, input bit fl, input bit ak);
        int          idx, off, line;
        logic [31:0] tg;
        bit          hit;
        addr   = a;
        Flush  = fl;
        ack_en = ak;
        idx = int'((a / 16) % L);
        off = int'((a / 4) % W);
        tg  = a / (16 * L);
        #4;
        hit = !m_busy && m_vld[idx] && m_tag[idx] == tg;
        check("valid", 32'(Valid), hit ? 32'd1 : 32'd0);
        check("instr", Instr, hit ? m_data[idx][off] : 32'd0);
        check("mem_req", 32'(Mem_Req), 32'(m_busy));
        if (m_busy) check("mem_addr", Mem_Addr, m_base + 32'(4 * m_beat));
        @(posedge CLK);
        #1;
        if (!m_busy) begin
            if (fl) clear_all();
            if (!hit) begin
                m_busy  = 1'b1;
                m_base  = a & ~32'(W * 4 - 1);
                m_beat  = 0;
                m_dirty = 1'b0;
            end
        end else begin
            if (fl) begin
                m_dirty = 1'b1;
                clear_all();
            end
            if (ak) begin
                line = int'((m_base / 16) % L);
                m_data[line][m_beat] = (m_base + 32'(4 * m_beat)) ^ K;
                m_beat++;
                if (m_beat == W) begin
                    m_busy      = 1'b0;
                    m_tag[line] = m_base / (16 * L);
                    if (!m_dirty) m_vld[line] = 1'b1;
                end
            end
        end
    endtask

    logic [31:0] pool [5] = '{RESET_VECTOR, RESET_VECTOR + 32'h400, RESET_VECTOR + 32'h100,
                              32'h0000_1230, RESET_VECTOR + 32'h10};

    initial begin
        RESET  = 1'b1;
        addr   = RESET_VECTOR;
        Flush  = 1'b0;
        ack_en = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_instr", Instr, 32'd0);
        check("rst_req", 32'(Mem_Req), 32'd0);
        check("rst_addr", Mem_Addr, 32'd0);
        RESET = 1'b0;

        repeat (6) step(RESET_VECTOR, 1'b0, 1'b1);
        addr = RESET_VECTOR;
        #1;
        check("rv_word", Instr, 32'h1A65A5A5);
        check("rv_valid", 32'(Valid), 32'd1);
        for (int i = 1; i < 4; i++) step(RESET_VECTOR + 32'(4 * i), 1'b0, 1'b1);

        repeat (6) step(RESET_VECTOR + 32'h400, 1'b0, 1'b1);
        repeat (6) step(RESET_VECTOR, 1'b0, 1'b1);

        for (int c = 0; c < 40; c++)
            step(c < 5 ? RESET_VECTOR + 32'h400 : RESET_VECTOR + 32'h100, 1'b0, c % 3 == 2);

        step(RESET_VECTOR + 32'h40, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) step(RESET_VECTOR + 32'h40, b == 2, 1'b1);
        repeat (6) step(RESET_VECTOR + 32'h40, 1'b0, 1'b1);

        step(RESET_VECTOR, 1'b0, 1'b1);
        step(RESET_VECTOR, 1'b0, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        check("midrst_req", 32'(Mem_Req), 32'd0);
        check("midrst_valid", 32'(Valid), 32'd0);
        check("midrst_instr", Instr, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        repeat (6) step(RESET_VECTOR, 1'b0, 1'b1);

        for (int c = 0; c < 3000; c++)
            step(pool[$urandom_range(4)] + 32'(4 * $urandom_range(3)),
                 $urandom_range(19) == 0, $urandom_range(3) != 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
